// File: rtl/regfile_pkg.sv
// Shared sizing and small types for the register-file writeback arbiter.
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

    function automatic logic is_x0(input logic [REG_AW-1:0] rd);
        return rd == '0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; pri selects the winner on contention
// and flips only after a contended cycle.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic pri_q;
    logic pri_d;

    always_comb begin
        gnt0  = req0 & (~req1 | ~pri_q);
        gnt1  = req1 & (~req0 |  pri_q);
        pri_d = pri_q;
        // The winner was the one pri pointed at, so favouring the loser is a flip.
        if (req0 && req1) begin
            pri_d = ~pri_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto one registered register-file write
// port, with a load scoreboard that blocks WAW writes and flags RAW hazards.
module regfile_wb_arbiter #(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREG = regfile_pkg::NREG
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alu_valid,
    output logic                           alu_ready,
    input  logic [regfile_pkg::REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]                alu_data,
    input  logic                           ld_issue,
    input  logic [regfile_pkg::REG_AW-1:0] ld_issue_rd,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [regfile_pkg::REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]                ld_data,
    input  logic [regfile_pkg::REG_AW-1:0] rs1_addr,
    input  logic [regfile_pkg::REG_AW-1:0] rs2_addr,
    output logic                           hazard,
    output logic                           rf_write,
    output logic [regfile_pkg::REG_AW-1:0] rf_addr,
    output logic [XLEN-1:0]                rf_data
);

    import regfile_pkg::*;

    logic [NREG-1:0]   busy_q, busy_d;
    logic              rf_write_q, rf_write_d;
    logic [REG_AW-1:0] rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]   rf_data_q, rf_data_d;
    logic              alu_elig, ld_elig;
    wb_src_e           src;

    // Gating with reset keeps the handshake quiet while reset is held.
    assign alu_elig = ~reset & alu_valid & ~busy_q[alu_rd];
    assign ld_elig  = ~reset & ld_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (alu_elig),
        .req1  (ld_elig),
        .gnt0  (alu_ready),
        .gnt1  (ld_ready)
    );

    assign hazard = ~reset & (busy_q[rs1_addr] | busy_q[rs2_addr]);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        src        = SRC_NONE;
        rf_write_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        if (alu_ready) begin
            src = SRC_ALU;
        end else if (ld_ready) begin
            src = SRC_LD;
        end
        case (src)
            SRC_ALU: begin
                rf_write_d = ~is_x0(alu_rd);
                rf_addr_d  = alu_rd;
                rf_data_d  = alu_data;
            end
            SRC_LD: begin
                rf_write_d = ~is_x0(ld_rd);
                rf_addr_d  = ld_rd;
                rf_data_d  = ld_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d = '0;
        // Set is OR'd after the clear so a same-edge reissue keeps the register busy.
        for (int i = 1; i < NREG; i++) begin
            busy_d[i] = (busy_q[i] & ~(ld_ready && ld_rd == REG_AW'(i)))
                      | (ld_issue && ld_issue_rd == REG_AW'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            busy_q     <= busy_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign rf_write = rf_write_q;
    assign rf_addr  = rf_addr_q;
    assign rf_data  = rf_data_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the register file.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (x0 included).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-006 SHALL have port alu_ready  output  1  ALU request granted this cycle.
REQ-007 SHALL have ports alu_rd  input  5 and alu_data  input  XLEN, ALU destination and result.
REQ-008 SHALL have ports ld_issue  input  1 and ld_issue_rd  input  5, load issued and its destination (scoreboard mark).
REQ-009 SHALL have port ld_valid  input  1  load-data writeback request.
REQ-010 SHALL have port ld_ready  output  1  load request granted this cycle.
REQ-011 SHALL have ports ld_rd  input  5 and ld_data  input  XLEN, load destination and data.
REQ-012 SHALL have ports rs1_addr, rs2_addr  input  5 each, source registers of the decoding instruction.
REQ-013 SHALL have port hazard  output  1  a source register awaits an outstanding load.
REQ-014 SHALL have ports rf_write  output  1, rf_addr  output  5, rf_data  output  XLEN, registered write port driving the register file.

Function
REQ-015 A request SHALL transfer when valid and ready are both high at a rising edge; ready SHALL be combinational from current valid, scoreboard and priority state.
REQ-016 At most one of alu_ready, ld_ready SHALL be high in any cycle.
REQ-017 alu_ready SHALL be low whenever busy[alu_rd] is set (WAW protection behind a pending load).
REQ-018 With only one eligible requester, it SHALL be granted; with both eligible, the one selected by priority bit pri (0 = ALU, 1 = load) SHALL be granted.
REQ-019 pri SHALL toggle to favour the non-granted requester only after a cycle in which both were eligible; otherwise pri holds.
REQ-020 A transfer SHALL produce rf_write=1 with rf_addr=rd and rf_data=data in the following cycle (latency 1); with no transfer, rf_write SHALL be 0 and rf_addr/rf_data SHALL hold.
REQ-021 A transfer with rd=0 SHALL be accepted (ready asserted) but SHALL produce rf_write=0.
REQ-022 Scoreboard busy[NREG-1:0]: ld_issue with ld_issue_rd!=0 SHALL set busy[ld_issue_rd] at the next edge; busy[0] SHALL always read 0.
REQ-023 A transferred load writeback SHALL clear busy[ld_rd] at the same edge.
REQ-024 Simultaneous set and clear of the same register SHALL leave it set (new load wins).
REQ-025 A load writeback to a non-busy register SHALL transfer normally with no scoreboard change.
REQ-026 hazard SHALL equal busy[rs1_addr] | busy[rs2_addr], combinational from registered busy (an ld_issue in the same cycle does not raise hazard until the next cycle).

Reset
REQ-027 On reset assertion, immediately and asynchronously: rf_write=0, rf_addr=0, rf_data=0, busy all 0, pri=0.
REQ-028 While reset is high, alu_ready and ld_ready SHALL be 0 and hazard SHALL be 0.
REQ-029 Reset mid-operation SHALL discard outstanding loads and any pending registered write; no rf_write pulse SHALL follow deassertion without a new transfer.

Structure
REQ-030 XLEN, NREG and the register-address width (5) SHALL live in shared package regfile_pkg.
REQ-031 Two-requester round-robin selection (eligibility in, grant and pri update out) SHALL be a sub-module rr_arb2; scoreboard and output register stay in the top.

Verification
REQ-032 ALU only: alu_valid, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1; next cycle rf_write=1, rf_addr=5, rf_data=0xDEADBEEF.
REQ-033 Contention: alu_valid and ld_valid held 4 cycles, rd 3/4, pri=0 -> grants ALU, load, ALU, load; four consecutive rf_write pulses.
REQ-034 Scoreboard: ld_issue rd=7; next cycle rs1_addr=7 -> hazard=1; alu_valid rd=7 -> alu_ready=0; ld writeback rd=7 data 0x12 -> hazard=0 after edge, rf_data=0x12.
REQ-035 x0: alu_valid rd=0 data 0xFFFFFFFF -> alu_ready=1, rf_write stays 0; ld_issue rd=0 -> busy[0] stays 0, hazard=0 for rs1=0.
REQ-036 Same-edge set/clear: busy[9] set, ld writeback rd=9 and ld_issue rd=9 same cycle -> busy[9] remains 1, rf_write to 9 occurs.
REQ-037 Reset mid-op: busy[2] set, transfer accepted, assert reset before next edge -> rf_write=0 immediately, hazard=0, busy cleared, no write after deassertion.
